// File: rtl/sc_pos_decounter.sv
// sc_pos_decounter: position down-counter driven by an active-low push-button.
// A press steps the position down once. Holding the button steps it again after
// HOLD_CYCLES, then every REPEAT_CYCLES. Also provides parallel load, a zero flag,
// and registered step/underflow pulses.
// Optional feature macro: SC_POSDECOUNTER_WRAP_EN. When undefined, a step at 0
// saturates. When defined, a step at 0 wraps to all ones.
module sc_pos_decounter #(
    parameter int unsigned DATAWIDTH     = 3,
    parameter int unsigned RESET_VALUE   = 7,
    parameter int unsigned TIMER_WIDTH   = 16,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned REPEAT_CYCLES = 4
) (
    input  logic                 SC_posDECOUNTER_CLOCK_50,
    input  logic                 SC_posDECOUNTER_RESET_InLow,
    input  logic                 SC_posDECOUNTER_downcount_InLow,
    input  logic                 SC_posDECOUNTER_load_InLow,
    input  logic [DATAWIDTH-1:0] SC_posDECOUNTER_data_InBUS,
    output logic [DATAWIDTH-1:0] SC_posDECOUNTER_data_OutBUS,
    output logic                 SC_posDECOUNTER_zero_OutHigh,
    output logic                 SC_posDECOUNTER_step_OutHigh,
    output logic                 SC_posDECOUNTER_underflow_OutHigh
);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRepeat
    } state_e;

    // Terminal timer counts. The timer never counts past these values.
    localparam logic [TIMER_WIDTH-1:0] HoldLast   = TIMER_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] RepeatLast = TIMER_WIDTH'(REPEAT_CYCLES - 1);
    localparam logic [DATAWIDTH-1:0]   ResetPos   = DATAWIDTH'(RESET_VALUE);
    localparam logic [DATAWIDTH-1:0]   OnePos     = DATAWIDTH'(1);

    // Request path. Both stages reset to 0, which reads as "asserted".
    // A button held through reset therefore produces no press event.
    logic reqSync_q;
    logic reqDly_q;
    logic pressEvt;
    logic held;

    // FSM and hold/repeat timer
    state_e                 state_q;
    state_e                 state_d;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [TIMER_WIDTH-1:0] timer_d;
    logic                   stepDue;

    // Position and pulse registers
    logic [DATAWIDTH-1:0] pos_q;
    logic [DATAWIDTH-1:0] pos_d;
    logic                 step_q;
    logic                 step_d;
    logic                 underflow_q;
    logic                 underflow_d;

    logic loadEn;

    assign loadEn   = ~SC_posDECOUNTER_load_InLow;
    assign pressEvt = reqDly_q & ~reqSync_q;
    assign held     = ~reqSync_q;

    // Sample the request pin and keep one previous sample for edge detection.
    always_ff @(posedge SC_posDECOUNTER_CLOCK_50) begin
        if (!SC_posDECOUNTER_RESET_InLow) begin
            reqSync_q <= 1'b0;
            reqDly_q  <= 1'b0;
        end else begin
            reqSync_q <= SC_posDECOUNTER_downcount_InLow;
            reqDly_q  <= reqSync_q;
        end
    end

    // Register the FSM state and the hold/repeat timer.
    always_ff @(posedge SC_posDECOUNTER_CLOCK_50) begin
        if (!SC_posDECOUNTER_RESET_InLow) begin
            state_q <= StIdle;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Compute the next state and timer value, and decide whether a step is due.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        stepDue = 1'b0;
        if (loadEn) begin
            // Load aborts any sequence. A step due in this cycle is dropped.
            state_d = StIdle;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pressEvt) begin
                        stepDue = 1'b1;
                        timer_d = '0;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (!held) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else if (timer_q == HoldLast) begin
                        stepDue = 1'b1;
                        timer_d = '0;
                        state_d = StRepeat;
                    end else begin
                        timer_d = timer_q + TIMER_WIDTH'(1);
                    end
                end
                StRepeat: begin
                    if (!held) begin
                        state_d = StIdle;
                        timer_d = '0;
                    end else if (timer_q == RepeatLast) begin
                        stepDue = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Compute the next position and the step/underflow pulses (load beats step).
    always_comb begin
        pos_d       = pos_q;
        step_d      = 1'b0;
        underflow_d = 1'b0;
        if (loadEn) begin
            pos_d = SC_posDECOUNTER_data_InBUS;
        end else if (stepDue) begin
            if (pos_q != '0) begin
                pos_d  = pos_q - OnePos;
                step_d = 1'b1;
            end else begin
`ifdef SC_POSDECOUNTER_WRAP_EN
                pos_d       = '1;
                step_d      = 1'b1;
                underflow_d = 1'b1;
`else
                underflow_d = 1'b1;
`endif
            end
        end
    end

    // Register the position and the single-cycle pulses.
    always_ff @(posedge SC_posDECOUNTER_CLOCK_50) begin
        if (!SC_posDECOUNTER_RESET_InLow) begin
            pos_q       <= ResetPos;
            step_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pos_q       <= pos_d;
            step_q      <= step_d;
            underflow_q <= underflow_d;
        end
    end

    assign SC_posDECOUNTER_data_OutBUS       = pos_q;
    assign SC_posDECOUNTER_zero_OutHigh      = (pos_q == '0);
    assign SC_posDECOUNTER_step_OutHigh      = step_q;
    assign SC_posDECOUNTER_underflow_OutHigh = underflow_q;

endmodule

// File: tb/tb_sc_pos_decounter.sv
// Testbench for sc_pos_decounter with default parameters.
// Expectations follow SC_POSDECOUNTER_WRAP_EN if the bench is built with it.
module tb_sc_pos_decounter;

    localparam int W = 3;
`ifdef SC_POSDECOUNTER_WRAP_EN
    localparam bit Wrap = 1'b1;
`else
    localparam bit Wrap = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstN;
    logic         dnN;
    logic         ldN;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         zero;
    logic         step;
    logic         uf;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic         dn;
        logic         ld;
        logic [W-1:0] din;
        logic [W-1:0] eData;
        logic         eZero;
        logic         eStep;
        logic         eUf;
    } vec_t;

    vec_t vecs[14];

    sc_pos_decounter dut (
        .SC_posDECOUNTER_CLOCK_50         (clk),
        .SC_posDECOUNTER_RESET_InLow      (rstN),
        .SC_posDECOUNTER_downcount_InLow  (dnN),
        .SC_posDECOUNTER_load_InLow       (ldN),
        .SC_posDECOUNTER_data_InBUS       (din),
        .SC_posDECOUNTER_data_OutBUS      (dout),
        .SC_posDECOUNTER_zero_OutHigh     (zero),
        .SC_posDECOUNTER_step_OutHigh     (step),
        .SC_posDECOUNTER_underflow_OutHigh(uf)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag, input int eData, input int eZero,
                            input int eStep, input int eUf);
        check({tag, " data"}, int'(dout), eData);
        check({tag, " zero"}, int'(zero), eZero);
        check({tag, " step"}, int'(step), eStep);
        check({tag, " underflow"}, int'(uf), eUf);
    endtask

    task automatic runVecs(input string tag, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            dnN = vecs[i].dn;
            ldN = vecs[i].ld;
            din = vecs[i].din;
            tick();
            checkAll($sformatf("%s[%0d]", tag, i), int'(vecs[i].eData), int'(vecs[i].eZero),
                     int'(vecs[i].eStep), int'(vecs[i].eUf));
        end
    endtask

    // Step edges while held, counted from the edge where the low pin is first sampled.
    function automatic bit isStepEdge(input int e);
        return (e == 2) || (e >= 10 && e <= 30 && ((e - 10) % 4) == 0);
    endfunction

    initial begin
        int pos;
        int eStep;
        int eUf;
        int ePos;

        // Single press from 7 (pin low for three cycles).
        vecs[0]  = '{1'b1, 1'b1, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 3'd0, 3'd6, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0};
        // Load 0, then a single press at position 0.
        vecs[8]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 3'd0, Wrap ? 3'd7 : 3'd0, !Wrap, Wrap, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 3'd0, Wrap ? 3'd7 : 3'd0, !Wrap, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 3'd0, Wrap ? 3'd7 : 3'd0, !Wrap, 1'b0, 1'b0};

        // Reset with the button held low throughout.
        rstN = 1'b0;
        dnN  = 1'b0;
        ldN  = 1'b1;
        din  = '0;
        tick();
        tick();
        checkAll("reset", 7, 0, 0, 0);
        rstN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkAll($sformatf("heldThroughReset%0d", i), 7, 0, 0, 0);
        end

        runVecs("press", 0, 7);

        // Hold for 30 cycles starting from 6; the last step attempt lands on 0.
        pos = 6;
        for (int e = 1; e <= 34; e++) begin
            dnN = (e <= 30) ? 1'b0 : 1'b1;
            tick();
            eStep = 0;
            eUf   = 0;
            if (isStepEdge(e)) begin
                if (pos > 0) begin
                    pos--;
                    eStep = 1;
                end else if (Wrap) begin
                    pos   = 7;
                    eStep = 1;
                    eUf   = 1;
                end else begin
                    eUf = 1;
                end
            end
            checkAll($sformatf("hold e%0d", e), pos, (pos == 0) ? 1 : 0, eStep, eUf);
        end

        runVecs("zeroPress", 8, 13);

        // Load 6, hold into REPEAT, then load 5 on the cycle a step is due.
        dnN = 1'b1;
        ldN = 1'b0;
        din = 3'd6;
        tick();
        checkAll("load6", 6, 0, 0, 0);
        ldN = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            dnN = ((e >= 27 && e <= 28) || e >= 31) ? 1'b1 : 1'b0;
            ldN = (e == 14) ? 1'b0 : 1'b1;
            din = 3'd5;
            tick();
            if (e < 2)       ePos = 6;
            else if (e < 10) ePos = 5;
            else if (e < 14) ePos = 4;
            else if (e < 30) ePos = 5;
            else             ePos = 4;
            eStep = (e == 2 || e == 10 || e == 30) ? 1 : 0;
            checkAll($sformatf("loadRepeat e%0d", e), ePos, 0, eStep, 0);
        end
        ldN = 1'b1;

        // Reset asserted while in HOLD with the timer at 5.
        ldN = 1'b0;
        din = 3'd3;
        tick();
        checkAll("load3", 3, 0, 0, 0);
        ldN = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            dnN  = ((e >= 21 && e <= 22) || e == 25) ? 1'b1 : 1'b0;
            rstN = (e == 8 || e == 9) ? 1'b0 : 1'b1;
            tick();
            if (e < 2)       ePos = 3;
            else if (e < 8)  ePos = 2;
            else if (e < 24) ePos = 7;
            else             ePos = 6;
            eStep = (e == 2 || e == 24) ? 1 : 0;
            checkAll($sformatf("resetHold e%0d", e), ePos, 0, eStep, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
